// File: rtl/dmem_mmio_responder.sv
// Data-port responder: word-addressed RAM plus a small MMIO block holding a
// free-running timer with compare/match flag, interrupt output and GPIO register.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] GpioOut,
  output logic        Irq
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  localparam logic [5:0] OFF_TIMER  = 6'h00;
  localparam logic [5:0] OFF_CMP    = 6'h01;
  localparam logic [5:0] OFF_CTRL   = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;
  localparam logic [5:0] OFF_GPIO   = 6'h04;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        flag_q, flag_d;
  logic [31:0] gpio_q, gpio_d;

  logic          ram_hit;
  logic          mmio_hit;
  logic [5:0]    reg_off;
  logic [AW-1:0] word_idx;

  logic ram_we;
  logic timer_we;
  logic cmp_we;
  logic ctrl_we;
  logic status_we;
  logic gpio_we;
  logic match;

  assign ram_hit  = (ALUResult < RAM_BYTES);
  assign mmio_hit = (ALUResult[31:8] == MMIO_BASE[31:8]);
  assign reg_off  = ALUResult[7:2];
  assign word_idx = ALUResult[AW+1:2];

  assign ram_we    = MemWrite && ram_hit;
  assign timer_we  = MemWrite && mmio_hit && (reg_off == OFF_TIMER);
  assign cmp_we    = MemWrite && mmio_hit && (reg_off == OFF_CMP);
  assign ctrl_we   = MemWrite && mmio_hit && (reg_off == OFF_CTRL);
  assign status_we = MemWrite && mmio_hit && (reg_off == OFF_STATUS);
  assign gpio_we   = MemWrite && mmio_hit && (reg_off == OFF_GPIO);

  // A software TIMER write suppresses both counting and match evaluation.
  assign match = !timer_we && ctrl_q[0] && (timer_q == cmp_q);

  // RAM has no reset: contents survive a reset pulse.
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      mem_q[word_idx] <= WriteData;
    end
  end

  always_comb begin
    timer_d = timer_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    flag_d  = flag_q;
    gpio_d  = gpio_q;

    if (timer_we) begin
      timer_d = WriteData;
    end else if (match) begin
      timer_d = '0;
    end else if (ctrl_q[0]) begin
      timer_d = timer_q + 32'd1;
    end

    if (cmp_we) begin
      cmp_d = WriteData;
    end
    if (ctrl_we) begin
      ctrl_d = WriteData[1:0];
    end
    if (gpio_we) begin
      gpio_d = WriteData;
    end

    // Clear first so that a same-edge match takes precedence.
    if (status_we && WriteData[0]) begin
      flag_d = 1'b0;
    end
    if (match) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      ctrl_q  <= '0;
      flag_q  <= 1'b0;
      gpio_q  <= '0;
    end else begin
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
      gpio_q  <= gpio_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = mem_q[word_idx];
    end else if (mmio_hit) begin
      case (reg_off)
        OFF_TIMER:  ReadData = timer_q;
        OFF_CMP:    ReadData = cmp_q;
        OFF_CTRL:   ReadData = {30'd0, ctrl_q};
        OFF_STATUS: ReadData = {31'd0, flag_q};
        OFF_GPIO:   ReadData = gpio_q;
        default:    ReadData = '0;
      endcase
    end
  end

  assign GpioOut = gpio_q;
  assign Irq     = flag_q && ctrl_q[1];

endmodule
